// File: rtl/lc3_arb_pkg.sv
// Shared types and default widths for the LC3 unified-memory arbiter.
package lc3_arb_pkg;

    localparam int DEF_ADDR_W          = 16;
    localparam int DEF_DATA_W          = 16;
    localparam int DEF_MAX_DATA_STREAK = 4;
    localparam int DEF_TIMEOUT_CYC     = 64;
    localparam int STREAK_W            = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } arb_state_t;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } arb_src_t;

endpackage

// File: rtl/lc3_arb_watchdog.sv
// Busy-cycle watchdog for the arbiter: counts unacknowledged memory wait cycles
// and raises a sticky error when a transaction is forced to complete.
module lc3_arb_watchdog
    import lc3_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic expired,
    output logic timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    // An ack in the limit cycle still wins over the timeout.
    assign expired = active && !ack && (count == LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (active && !ack && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (expired) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbitrates LC3 fetch and MemAccess requests onto one single-port memory.
// Optional watchdog enabled by defining LC3_ARB_TIMEOUT_EN.
module lc3_mem_arbiter
    import lc3_arb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
    parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_dout,
    output logic              complete_instr,
    input  logic              data_req,
    input  logic              data_rd,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_din,
    output logic [DATA_W-1:0] data_dout,
    output logic              complete_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_t          state;
    arb_state_t          state_next;
    arb_src_t            grant_src;
    logic                grant;
    logic                wd_expired;
    logic [STREAK_W-1:0] streak;

    // Data wins ties until the streak limit, then one fetch is let through.
    always_comb begin
        grant     = 1'b0;
        grant_src = SRC_INSTR;
        if (state == IDLE) begin
            if (data_req && !(instr_req && (streak == STREAK_MAX))) begin
                grant     = 1'b1;
                grant_src = SRC_DATA;
            end else if (instr_req) begin
                grant     = 1'b1;
                grant_src = SRC_INSTR;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = (grant_src == SRC_DATA) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ack || wd_expired) begin
                    state_next = DONE_I;
                end
            end
            BUSY_D: begin
                if (mem_ack || wd_expired) begin
                    state_next = DONE_D;
                end
            end
            DONE_I:  state_next = IDLE;
            DONE_D:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded from state so an async reset drops mem_req without waiting for a clock.
    assign mem_req        = (state == BUSY_I) || (state == BUSY_D);
    assign busy           = (state != IDLE);
    assign complete_instr = (state == DONE_I);
    assign complete_data  = (state == DONE_D);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (grant) begin
            if (grant_src == SRC_INSTR || !instr_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

    // Request is latched once at grant; requester inputs are ignored until IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (grant) begin
            if (grant_src == SRC_DATA) begin
                mem_addr  <= data_addr;
                mem_we    <= ~data_rd;
                mem_wdata <= data_din;
            end else begin
                mem_addr  <= instr_addr;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_dout <= '0;
            data_dout  <= '0;
        end else begin
            if (state == BUSY_I) begin
                if (mem_ack) begin
                    instr_dout <= mem_rdata;
                end else if (wd_expired) begin
                    instr_dout <= '1;
                end
            end
            if (state == BUSY_D && !mem_we) begin
                if (mem_ack) begin
                    data_dout <= mem_rdata;
                end else if (wd_expired) begin
                    data_dout <= '1;
                end
            end
        end
    end

`ifdef LC3_ARB_TIMEOUT_EN
    lc3_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clock       (clock),
        .reset       (reset),
        .clear       (grant),
        .active      (mem_req),
        .ack         (mem_ack),
        .expired     (wd_expired),
        .timeout_err (timeout_err)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign wd_expired         = 1'b0;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: table of single transactions plus
// hand-written fairness, spurious-ack, reset and (optional) timeout sequences.
module tb_lc3_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req = 1'b0;
    logic [15:0] instr_addr = '0;
    logic [15:0] instr_dout;
    logic        complete_instr;
    logic        data_req = 1'b0;
    logic        data_rd = 1'b0;
    logic [15:0] data_addr = '0;
    logic [15:0] data_din = '0;
    logic [15:0] data_dout;
    logic        complete_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    lc3_mem_arbiter #(
        .ADDR_W          (16),
        .DATA_W          (16),
        .MAX_DATA_STREAK (4),
        .TIMEOUT_CYC     (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .instr_req      (instr_req),
        .instr_addr     (instr_addr),
        .instr_dout     (instr_dout),
        .complete_instr (complete_instr),
        .data_req       (data_req),
        .data_rd        (data_rd),
        .data_addr      (data_addr),
        .data_din       (data_din),
        .data_dout      (data_dout),
        .complete_data  (complete_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_data;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] rdata;
        int          waits;
        logic        exp_we;
        int          exp_lat;
        logic [15:0] exp_instr_dout;
        logic [15:0] exp_data_dout;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        instr_req = 1'b0;
        data_req  = 1'b0;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Drives one request from IDLE, plays the memory with v.waits wait cycles,
    // and measures cycles from the grant cycle to the completion pulse.
    task automatic apply_stimulus(input vec_t v);
        int  cyc;
        int  busy_cyc;
        bit  done;
        instr_req  = !v.is_data;
        data_req   = v.is_data;
        data_rd    = v.rd;
        instr_addr = v.addr;
        data_addr  = v.addr;
        data_din   = v.din;
        mem_rdata  = v.rdata;
        cyc = 0;
        busy_cyc = 0;
        done = 0;
        while (!done && cyc < 40) begin
            if (mem_req) begin
                if (busy_cyc == 0) begin
                    check_output("mem_addr", 32'(mem_addr), 32'(v.addr));
                    check_output("mem_we", 32'(mem_we), 32'(v.exp_we));
                    if (v.is_data && !v.rd)
                        check_output("mem_wdata", 32'(mem_wdata), 32'(v.din));
                end
                mem_ack = (busy_cyc == v.waits);
                busy_cyc++;
            end else begin
                mem_ack = 1'b0;
            end
            tick();
            mem_ack = 1'b0;
            cyc++;
            if (complete_instr || complete_data) done = 1;
        end
        if (!done) begin
            failures++;
            checks++;
            $display("[TB] FAIL completion_timeout actual=none expected=pulse");
        end else begin
            check_output("latency", 32'(cyc), 32'(v.exp_lat));
            check_output("complete_instr", 32'(complete_instr), 32'(!v.is_data));
            check_output("complete_data", 32'(complete_data), 32'(v.is_data));
            check_output("mem_req_done", 32'(mem_req), 32'd0);
            check_output("instr_dout", 32'(instr_dout), 32'(v.exp_instr_dout));
            check_output("data_dout", 32'(data_dout), 32'(v.exp_data_dout));
        end
        tick();
        instr_req = 1'b0;
        data_req  = 1'b0;
        check_output("pulse_width", 32'({complete_instr, complete_data}), 32'd0);
        check_output("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic exp_order[10];
        int   n;

        vecs[0] = '{1'b0, 1'b1, 16'h3000, 16'h0000, 16'h1261, 2, 1'b0, 4, 16'h1261, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 16'h3020, 16'h0000, 16'h5A5A, 1, 1'b0, 3, 16'h1261, 16'h5A5A};
        vecs[2] = '{1'b1, 1'b0, 16'h3010, 16'hBEEF, 16'h1111, 0, 1'b1, 2, 16'h1261, 16'h5A5A};
        vecs[3] = '{1'b0, 1'b1, 16'h3001, 16'h0000, 16'h1234, 0, 1'b0, 2, 16'h1234, 16'h5A5A};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFE, 16'h0000, 16'h0001, 3, 1'b0, 5, 16'h1234, 16'h0001};
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        do_reset();
        check_output("rst_mem_req", 32'(mem_req), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_complete", 32'({complete_instr, complete_data}), 32'd0);
        check_output("rst_mem_addr", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
        check_output("rst_dout", 32'({instr_dout, data_dout}), 32'd0);
        check_output("rst_timeout_err", 32'(timeout_err), 32'd0);

        for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

        // Spurious ack while idle must not start anything.
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("spurious_busy", 32'({busy, mem_req}), 32'd0);
            check_output("spurious_complete", 32'({complete_instr, complete_data}), 32'd0);
        end
        mem_ack = 1'b0;

        // Fairness with both requesters held high and a zero-wait memory.
        do_reset();
        instr_addr = 16'h3000;
        data_addr  = 16'h4000;
        data_rd    = 1'b1;
        instr_req  = 1'b1;
        data_req   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n = 0;
            while (!mem_req && n < 8) begin
                tick();
                n++;
            end
            if (!mem_req) begin
                checks++;
                failures++;
                $display("[TB] FAIL grant_wait k=%0d actual=no_req expected=req", k);
            end else begin
                check_output($sformatf("grant_order_%0d", k), 32'(mem_addr == 16'h4000),
                             32'(exp_order[k]));
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            tick();
        end
        instr_req = 1'b0;
        data_req  = 1'b0;
        tick();

        // Async reset in the middle of a data access.
        do_reset();
        data_req  = 1'b1;
        data_rd   = 1'b1;
        data_addr = 16'h3050;
        tick();
        tick();
        check_output("pre_reset_mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("async_mem_req", 32'(mem_req), 32'd0);
        check_output("async_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        data_req = 1'b0;
        mem_ack  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_ack = 1'b0;
            check_output("post_reset_complete", 32'(complete_data), 32'd0);
            check_output("post_reset_busy", 32'(busy), 32'd0);
        end

`ifdef LC3_ARB_TIMEOUT_EN
        // Memory never acks: 8 BUSY cycles then a forced completion.
        do_reset();
        instr_req  = 1'b1;
        instr_addr = 16'h3000;
        n = 0;
        while (!complete_instr && n < 40) begin
            tick();
            n++;
        end
        check_output("timeout_latency", 32'(n), 32'd9);
        check_output("timeout_dout", 32'(instr_dout), 32'h0000FFFF);
        check_output("timeout_err_set", 32'(timeout_err), 32'd1);
        tick();
        instr_req = 1'b0;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        check_output("timeout_late_ack", 32'({busy, complete_instr}), 32'd0);
        check_output("timeout_err_sticky", 32'(timeout_err), 32'd1);
        do_reset();
        check_output("timeout_err_cleared", 32'(timeout_err), 32'd0);
`else
        check_output("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares one single-port unified memory between the LC3 instruction fetch path and the MemAccess data path.
- Serializes requests and drives the external memory handshake.
- Returns the completion pulses `complete_instr` and `complete_data` to the pipeline controller.
- Sits between the LC3 core memory ports and the memory model/driver. It is the variable-latency source the controller's stall logic reacts to.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while an instruction request waits (range 1..15).
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clock in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high.
- instr_req in 1: fetch request, level.
- instr_addr in ADDR_W: fetch address (pc).
- instr_dout out DATA_W: fetched instruction.
- complete_instr out 1: one-cycle fetch completion pulse.
- data_req in 1: data request, level.
- data_rd in 1: 1 = read, 0 = write.
- data_addr in ADDR_W: data address.
- data_din in DATA_W: write data.
- data_dout out DATA_W: read data.
- complete_data out 1: one-cycle data completion pulse.
- mem_req out 1: memory request.
- mem_we out 1: memory write enable.
- mem_addr out ADDR_W: memory address.
- mem_wdata out DATA_W: memory write data.
- mem_rdata in DATA_W: memory read data, valid with mem_ack.
- mem_ack in 1: memory acknowledge, one cycle.
- busy out 1: high in any non-IDLE state.
- timeout_err out 1: sticky watchdog error.

Behaviour:
- Reset values: all outputs 0, state IDLE, streak counter 0, watchdog counter 0. Async reset mid-transaction drops mem_req immediately; the in-flight access is abandoned and no completion pulse is issued.
- States:
  - IDLE: sample requests.
  - BUSY_I and BUSY_D: mem_req=1, waiting for mem_ack.
  - DONE_I and DONE_D: completion cycle.
- Grant in IDLE:
  - Only data_req -> BUSY_D.
  - Only instr_req -> BUSY_I.
  - Both -> BUSY_D, unless streak == MAX_DATA_STREAK, in which case BUSY_I.
  - Neither -> stay in IDLE.
- Streak counter:
  - Increments on each data grant made while instr_req=1, saturating at MAX_DATA_STREAK.
  - Clears on any instruction grant.
  - Clears on a data grant made while instr_req=0.
- Address/data latch: mem_addr, mem_we (= ~data_rd for data, 0 for fetch) and mem_wdata are registered at the grant edge and held stable through BUSY_*.
  - Requester inputs are not re-sampled until the next IDLE.
- BUSY_*:
  - mem_ack=1 -> DONE_*, mem_req=0 at that edge.
  - For reads, mem_rdata is captured into instr_dout (BUSY_I) or data_dout (BUSY_D) at the ack edge.
  - For writes, data_dout is held.
- DONE_*:
  - complete_instr or complete_data is high for exactly this cycle.
  - Next state is always IDLE; requests are ignored during DONE.
  - The requester deasserts or changes its request on the edge ending the DONE cycle.
- Latency: with zero memory wait (ack in the first BUSY cycle), grant edge to completion pulse is 2 cycles. Each wait cycle adds 1. Minimum back-to-back period is 3 cycles.
- mem_ack received in IDLE or DONE is ignored.
- instr_dout and data_dout hold their last values between transactions.

Optional Feature:
- Macro: LC3_ARB_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears at grant and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYC-1 without ack, the FSM goes to DONE_*, issues the completion pulse, and forces the read output to all-ones (16'hFFFF).
  - timeout_err is set and stays set until reset.
  - A late mem_ack arriving afterwards is ignored.
- Without the macro: BUSY waits indefinitely, timeout_err is tied to 0, and the port is retained.

Decomposition:
- Package lc3_arb_pkg holds:
  - state enum arb_state_t (IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D);
  - source enum arb_src_t (SRC_INSTR, SRC_DATA);
  - the default width constants.
- Sub-module lc3_arb_watchdog holds the counter plus the sticky error. It is instantiated only under LC3_ARB_TIMEOUT_EN.

Test Plan:
1. Single fetch: instr_req=1, instr_addr=16'h3000, mem_rdata=16'h1261 with ack after 2 wait cycles -> mem_addr=16'h3000, mem_we=0, complete_instr 4 cycles after grant, instr_dout=16'h1261.
2. Data write: data_req=1, data_rd=0, data_addr=16'h3010, data_din=16'hBEEF -> mem_we=1, mem_wdata=16'hBEEF, complete_data pulse, data_dout unchanged.
3. Fairness: data_req and instr_req held high continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
4. Spurious ack: mem_ack=1 while in IDLE with no request -> no state change, no completion pulse.
5. Reset mid-BUSY_D: assert reset while mem_req=1 -> mem_req=0 asynchronously, no complete_data, state IDLE after release.
6. With LC3_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, mem_ack never asserted -> complete_instr pulse after 8 BUSY cycles, instr_dout=16'hFFFF, timeout_err=1 until reset.
